ifetch_unit: RTL and testbench
==============================

# ifetch_unit

Instruction fetch stage placed directly upstream of the main decoder. It owns the program counter and issues one 32-bit instruction request at a time to instruction memory over a req/ack + rvalid interface. It registers each returned word together with its PC and hands it downstream over a valid/ready handshake; decode consumes instr[31:21] as its opcode field. Branch redirects from execute reload the PC and squash any fetch in flight.

## Interface
- N, default 64: PC and address width.
- RESET_PC, default 0: PC value loaded on reset.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- imem_req  out  1  request valid; held high until imem_ack.
- imem_addr  out  N  byte address of the request; always equals PC.
- imem_ack  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  read data valid; exactly one per accepted request.
- imem_rdata  in  32  instruction word.
- instr_valid  out  1  instr and instr_pc hold a valid fetched instruction.
- instr  out  32  fetched instruction word.
- instr_pc  out  N  PC of instr.
- instr_ready  in  1  downstream consumes instr when instr_valid is also high.
- redirect  in  1  taken branch; reload PC.
- redirect_pc  in  N  branch target.
- misalign  out  1  sticky alignment fault; present only with IFETCH_ALIGN_CHECK_EN.

## Operation
- FSM states: IDLE, REQ, WAIT, HOLD.
- IDLE: reset state. Moves to REQ on the first clock after reset deasserts.
- REQ: imem_req=1. On imem_ack, moves to WAIT.
- WAIT: On imem_rvalid, captures rdata into instr and PC into instr_pc, then moves to HOLD. If the drop flag is set, the word is discarded, drop is cleared and the FSM moves to REQ.
- HOLD: instr_valid=1. On instr_ready, PC←PC+4 (mod 2^N, wraps silently) and the FSM moves to REQ.
- Redirect has priority over every other transition:
  - PC←redirect_pc.
  - instr_valid is cleared.
  - Next state is REQ, except when a request is outstanding: the FSM is in WAIT with no rvalid, or in REQ with imem_ack the same cycle. In that case the next state is WAIT with drop=1.
  - Redirect in WAIT coinciding with rvalid: the word is discarded and the next state is REQ.
  - Redirect in HOLD coinciding with instr_ready: the handoff still occurs. Downstream sees the transfer; the PC takes redirect_pc, not PC+4.
- At most one outstanding request. imem_req is never asserted in WAIT or HOLD.
- Back-to-back redirects: the last one wins. drop is a single bit and stays set until the outstanding response arrives.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, misalign=0, drop=0.
- Minimum latency with ack in the same cycle as req and rvalid one cycle later:
  - Cycle 0: req and ack.
  - Cycle 1: rvalid.
  - Cycle 2: instr_valid.
  - Cycle 3: next req, if ready was high in cycle 2.
- Throughput: one instruction per 3 cycles at best.
- instr and instr_pc are stable while instr_valid=1 and instr_ready=0.
- A reset assertion mid-operation forces IDLE immediately. Any response arriving after reset, while in IDLE/REQ, is ignored.
- imem_addr is combinational from the PC register; no path from any input to any output is combinational.

## Configuration
- IFETCH_ALIGN_CHECK_EN defined:
  - A redirect with redirect_pc[1:0]≠0 sets the sticky misalign=1 (cleared only by reset).
  - The PC is loaded with redirect_pc[1:0] forced to 0.
  - Fetching continues from the aligned address.
- IFETCH_ALIGN_CHECK_EN undefined:
  - The misalign port is absent.
  - redirect_pc is loaded unmodified.

## Test plan
- Reset release, memory acks immediately, rvalid +1, ready held 1 -> addresses 0x0, 0x4, 0x8 issued on cycles 0, 3, 6; instr_pc matches; instr equals returned words.
- instr_ready held 0 for 5 cycles in HOLD -> instr/instr_pc stable, imem_req=0 throughout; PC advances by 4 only after ready.
- Redirect to 0x100 while in WAIT, then stale rvalid returns 0xDEADBEEF -> word never appears on instr; next imem_addr=0x100, and its returned word is delivered with instr_pc=0x100.
- Redirect in HOLD coinciding with instr_ready, current pc 0x20, target 0x80 -> the 0x20 instruction is transferred once; next request address is 0x80, not 0x24.
- PC=2^N−4 delivered and consumed -> next imem_addr=0.
- With IFETCH_ALIGN_CHECK_EN, redirect_pc=0x103 -> misalign=1 next cycle, imem_addr=0x100, misalign stays 1 until reset is asserted.

Source files
------------

// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - instruction fetch stage: PC owner, single-outstanding imem requester, valid/ready handoff to decode
// Optional feature macro: IFETCH_ALIGN_CHECK_EN (redirect alignment check with sticky misalign output)
`timescale 1ns/1ps
module ifetch_unit #(
    parameter int           N        = 64,
    parameter logic [N-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         reset,
    output logic         imem_req,
    output logic [N-1:0] imem_addr,
    input  logic         imem_ack,
    input  logic         imem_rvalid,
    input  logic [31:0]  imem_rdata,
    output logic         instr_valid,
    output logic [31:0]  instr,
    output logic [N-1:0] instr_pc,
    input  logic         instr_ready,
    input  logic         redirect,
    input  logic [N-1:0] redirect_pc
`ifdef IFETCH_ALIGN_CHECK_EN
    ,
    output logic         misalign
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic          r_drop;
    logic          w_next_drop;
    logic [N-1:0]  r_pc;
    logic [N-1:0]  w_next_pc;
    logic [31:0]   r_instr;
    logic [N-1:0]  r_instr_pc;
    logic          w_capture;
    logic [N-1:0]  w_redirect_target;
    logic          w_outstanding;

`ifdef IFETCH_ALIGN_CHECK_EN
    logic          r_misalign;

    // Fetch continues from the word-aligned target; the low bits only raise the fault.
    assign w_redirect_target = {redirect_pc[N-1:2], 2'b00};
    assign misalign          = r_misalign;

    // Sticky alignment fault, cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_misalign <= 1'b0;
        end else if (redirect && (redirect_pc[1:0] != 2'b00)) begin
            r_misalign <= 1'b1;
        end
    end
`else
    assign w_redirect_target = redirect_pc;
`endif

    // A request is in flight if memory accepted it and the response has not come back yet.
    assign w_outstanding = ((r_state == S_WAIT) && !imem_rvalid) ||
                           ((r_state == S_REQ)  && imem_ack);

    // Next-state, PC and drop-flag logic; redirect overrides the normal transitions.
    always_comb begin
        w_next_state = r_state;
        w_next_drop  = r_drop;
        w_next_pc    = r_pc;
        w_capture    = 1'b0;
        case (r_state)
            S_IDLE: w_next_state = S_REQ;
            S_REQ: begin
                if (imem_ack) w_next_state = S_WAIT;
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    if (r_drop) begin
                        w_next_drop  = 1'b0;
                        w_next_state = S_REQ;
                    end else begin
                        w_capture    = 1'b1;
                        w_next_state = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (instr_ready) begin
                    w_next_pc    = r_pc + {{(N-3){1'b0}}, 3'd4};
                    w_next_state = S_REQ;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
        if (redirect) begin
            w_next_pc = w_redirect_target;
            w_capture = 1'b0;
            if (w_outstanding) begin
                w_next_drop  = 1'b1;
                w_next_state = S_WAIT;
            end else begin
                w_next_state = S_REQ;
            end
        end
    end

    // State, PC and drop-flag registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_drop  <= 1'b0;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_next_state;
            r_drop  <= w_next_drop;
            r_pc    <= w_next_pc;
        end
    end

    // Capture the returned word with its PC; held steady until the next capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_instr    <= 32'd0;
            r_instr_pc <= '0;
        end else if (w_capture) begin
            r_instr    <= imem_rdata;
            r_instr_pc <= r_pc;
        end
    end

    assign imem_req    = (r_state == S_REQ);
    assign imem_addr   = r_pc;
    assign instr_valid = (r_state == S_HOLD);
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - directed self-checking bench for ifetch_unit
`timescale 1ns/1ps
module tb_ifetch_unit;

    localparam int N = 64;

    logic         clk;
    logic         rst_n;
    logic         imem_req;
    logic [N-1:0] imem_addr;
    logic         imem_ack;
    logic         imem_rvalid;
    logic [31:0]  imem_rdata;
    logic         instr_valid;
    logic [31:0]  instr;
    logic [N-1:0] instr_pc;
    logic         instr_ready;
    logic         redirect;
    logic [N-1:0] redirect_pc;
`ifdef IFETCH_ALIGN_CHECK_EN
    logic         misalign;
`endif

    int n_cmp;
    int n_bad;
    int cyc;

    ifetch_unit #(.N(N), .RESET_PC('0)) dut (
        .clk         (clk),
        .reset       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
`ifdef IFETCH_ALIGN_CHECK_EN
        ,
        .misalign    (misalign)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Wait (bounded) at negedges for imem_req; returns the address seen.
    task automatic wait_req(output logic [N-1:0] addr, output bit timed_out);
        timed_out = 1'b1;
        addr      = '0;
        for (int i = 0; i < 40; i++) begin
            if (imem_req === 1'b1) begin
                timed_out = 1'b0;
                addr      = imem_addr;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Called at a negedge with imem_req high: ack now, rvalid next cycle, returns in HOLD.
    task automatic respond(input logic [31:0] data);
        imem_ack = 1'b1;
        @(negedge clk);
        imem_ack    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        @(negedge clk);
        imem_rvalid = 1'b0;
        imem_rdata  = 32'd0;
    endtask

    task automatic test_reset;
        rst_n       = 1'b0;
        imem_ack    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'd0;
        instr_ready = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (imem_req !== 1'b0 || imem_addr !== 64'h0 || instr_valid !== 1'b0 ||
            instr !== 32'h0 || instr_pc !== 64'h0) begin
            n_bad++;
            $display("FAIL reset_values: req=%b addr=%h valid=%b instr=%h pc=%h, need 0/0/0/0/0",
                     imem_req, imem_addr, instr_valid, instr, instr_pc);
        end
`ifdef IFETCH_ALIGN_CHECK_EN
        n_cmp++;
        if (misalign !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_misalign: got %b need 0", misalign);
        end
`endif
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin
            n_bad++;
            $display("FAIL first_req: req=%b addr=%h, need 1 / 0", imem_req, imem_addr);
        end
    endtask

    task automatic test_basic;
        logic [N-1:0] a;
        bit           to;
        int           c0;
        logic [31:0]  words [3];
        words[0] = 32'h1111_0000;
        words[1] = 32'h2222_0004;
        words[2] = 32'h3333_0008;
        instr_ready = 1'b1;
        c0 = cyc;
        for (int i = 0; i < 3; i++) begin
            wait_req(a, to);
            n_cmp++;
            if (to || a !== 64'(4 * i) || (cyc - c0) != 3 * i) begin
                n_bad++;
                $display("FAIL basic_req%0d: timeout=%0d addr=%h cycle=%0d, need addr=%h cycle=%0d",
                         i, to, a, cyc - c0, 64'(4 * i), 3 * i);
            end
            respond(words[i]);
            n_cmp++;
            if (instr_valid !== 1'b1 || instr !== words[i] || instr_pc !== 64'(4 * i)) begin
                n_bad++;
                $display("FAIL basic_data%0d: valid=%b instr=%h pc=%h, need 1 %h %h",
                         i, instr_valid, instr, instr_pc, words[i], 64'(4 * i));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_stall;
        logic [N-1:0] a;
        bit           to;
        instr_ready = 1'b0;
        wait_req(a, to);
        n_cmp++;
        if (to || a !== 64'hC) begin
            n_bad++;
            $display("FAIL stall_req: timeout=%0d addr=%h, need 000000000000000c", to, a);
        end
        respond(32'h2222_3333);
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (instr_valid !== 1'b1 || instr !== 32'h2222_3333 || instr_pc !== 64'hC ||
                imem_req !== 1'b0 || imem_addr !== 64'hC) begin
                n_bad++;
                $display("FAIL stall_hold%0d: valid=%b instr=%h pc=%h req=%b addr=%h, need 1 22223333 c 0 c",
                         i, instr_valid, instr, instr_pc, imem_req, imem_addr);
            end
            @(negedge clk);
        end
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        n_cmp++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 64'h10) begin
            n_bad++;
            $display("FAIL stall_release: valid=%b req=%b addr=%h, need 0 1 10", instr_valid, imem_req, imem_addr);
        end
    endtask

    task automatic test_redirect_wait;
        logic [N-1:0] a;
        bit           to;
        wait_req(a, to);
        imem_ack = 1'b1;
        @(negedge clk);
        imem_ack    = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 64'h100;
        @(negedge clk);
        redirect = 1'b0;
        n_cmp++;
        if (imem_req !== 1'b0 || imem_addr !== 64'h100 || instr_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rdw_pending: req=%b addr=%h valid=%b, need 0 100 0", imem_req, imem_addr, instr_valid);
        end
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_rvalid = 1'b0;
        imem_rdata  = 32'd0;
        n_cmp++;
        if (instr_valid !== 1'b0 || instr === 32'hDEAD_BEEF || imem_req !== 1'b1 || imem_addr !== 64'h100) begin
            n_bad++;
            $display("FAIL rdw_stale: valid=%b instr=%h req=%b addr=%h, need 0 !deadbeef 1 100",
                     instr_valid, instr, imem_req, imem_addr);
        end
        respond(32'h0BAD_F00D);
        n_cmp++;
        if (instr_valid !== 1'b1 || instr !== 32'h0BAD_F00D || instr_pc !== 64'h100) begin
            n_bad++;
            $display("FAIL rdw_new: valid=%b instr=%h pc=%h, need 1 0badf00d 100", instr_valid, instr, instr_pc);
        end
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
    endtask

    task automatic test_redirect_hold;
        logic [N-1:0] a;
        bit           to;
        int           xfers;
        redirect    = 1'b1;
        redirect_pc = 64'h20;
        @(negedge clk);
        redirect = 1'b0;
        wait_req(a, to);
        n_cmp++;
        if (to || a !== 64'h20) begin
            n_bad++;
            $display("FAIL rdh_req: timeout=%0d addr=%h, need 20", to, a);
        end
        respond(32'h2020_2020);
        xfers       = 0;
        instr_ready = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 64'h80;
        if (instr_valid === 1'b1 && instr_pc === 64'h20) xfers++;
        @(negedge clk);
        redirect = 1'b0;
        if (instr_valid === 1'b1) xfers++;
        instr_ready = 1'b0;
        n_cmp++;
        if (xfers != 1 || imem_req !== 1'b1 || imem_addr !== 64'h80) begin
            n_bad++;
            $display("FAIL rdh_handoff: transfers=%0d req=%b addr=%h, need 1 1 80", xfers, imem_req, imem_addr);
        end
    endtask

    task automatic test_wrap;
        logic [N-1:0] a;
        bit           to;
        redirect    = 1'b1;
        redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        @(negedge clk);
        redirect = 1'b0;
        wait_req(a, to);
        respond(32'h7777_7777);
        n_cmp++;
        if (to || instr_valid !== 1'b1 || instr_pc !== 64'hFFFF_FFFF_FFFF_FFFC || instr !== 32'h7777_7777) begin
            n_bad++;
            $display("FAIL wrap_data: timeout=%0d valid=%b pc=%h instr=%h, need 1 fffffffffffffffc 77777777",
                     to, instr_valid, instr_pc, instr);
        end
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin
            n_bad++;
            $display("FAIL wrap_addr: req=%b addr=%h, need 1 0", imem_req, imem_addr);
        end
    endtask

    task automatic test_back_to_back;
        imem_ack    = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 64'h200;
        @(negedge clk);
        imem_ack    = 1'b0;
        redirect_pc = 64'h300;
        @(negedge clk);
        redirect = 1'b0;
        n_cmp++;
        if (imem_req !== 1'b0 || imem_addr !== 64'h300) begin
            n_bad++;
            $display("FAIL b2b_pending: req=%b addr=%h, need 0 300", imem_req, imem_addr);
        end
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAAD_BAAD;
        @(negedge clk);
        imem_rvalid = 1'b0;
        n_cmp++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 64'h300) begin
            n_bad++;
            $display("FAIL b2b_reissue: valid=%b req=%b addr=%h, need 0 1 300", instr_valid, imem_req, imem_addr);
        end
    endtask

    task automatic test_reset_mid;
        imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        rst_n    = 1'b0;
        #1;
        n_cmp++;
        if (imem_req !== 1'b0 || imem_addr !== 64'h0 || instr_valid !== 1'b0 || instr_pc !== 64'h0) begin
            n_bad++;
            $display("FAIL reset_mid: req=%b addr=%h valid=%b pc=%h, need 0 0 0 0",
                     imem_req, imem_addr, instr_valid, instr_pc);
        end
        @(negedge clk);
        rst_n       = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h5555_AAAA;
        @(negedge clk);
        imem_rvalid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (instr_valid !== 1'b0 || instr !== 32'h0 || imem_req !== 1'b1 || imem_addr !== 64'h0) begin
            n_bad++;
            $display("FAIL reset_stale: valid=%b instr=%h req=%b addr=%h, need 0 0 1 0",
                     instr_valid, instr, imem_req, imem_addr);
        end
    endtask

`ifdef IFETCH_ALIGN_CHECK_EN
    task automatic test_misalign;
        redirect    = 1'b1;
        redirect_pc = 64'h103;
        @(negedge clk);
        redirect = 1'b0;
        n_cmp++;
        if (misalign !== 1'b1 || imem_addr !== 64'h100) begin
            n_bad++;
            $display("FAIL misalign_set: misalign=%b addr=%h, need 1 100", misalign, imem_addr);
        end
        repeat (4) @(negedge clk);
        n_cmp++;
        if (misalign !== 1'b1) begin
            n_bad++;
            $display("FAIL misalign_sticky: got %b need 1", misalign);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (misalign !== 1'b0) begin
            n_bad++;
            $display("FAIL misalign_clear: got %b need 0", misalign);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask
`endif

    initial begin
        n_cmp = 0;
        n_bad = 0;
        cyc   = 0;
        test_reset;
        test_basic;
        test_stall;
        test_redirect_wait;
        test_redirect_hold;
        test_wrap;
        test_back_to_back;
        test_reset_mid;
`ifdef IFETCH_ALIGN_CHECK_EN
        test_misalign;
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
